logic_gate_checker: RTL

LOGIC_GATE_CHECKER -- requirements
Module: logic_gate_checker

---
 rtl/logic_gate_checker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/logic_gate_checker.sv
// Truth-table checker for a 2-input gate block: steps {a,b} through 00..11,
// waits SETTLE_CYCLES, compares gates_in. Option: GATE_CHK_MISMATCH_EN.
module logic_gate_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a_out,
   output logic       b_out,
   input  logic [6:0] gates_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_vector
`ifdef GATE_CHK_MISMATCH_EN
   ,
   output logic [6:0] mismatch_bits
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_nx;
   logic [1:0] vec;
   logic [1:0] vec_nx;
   logic [3:0] cnt;
   logic [6:0] expected;
   logic       miss;

   // {and,or,xor,not,nand,nor,xnor} for {a,b} = vec
   always_comb begin
      expected = 7'b0001111;
      unique case (vec)
         2'd0: expected = 7'b0001111;
         2'd1: expected = 7'b0111100;
         2'd2: expected = 7'b0110100;
         2'd3: expected = 7'b1100001;
      endcase
   end

   assign miss   = (gates_in != expected);
   assign vec_nx = vec + 2'd1;
   assign busy   = (state == SETTLE) || (state == CHECK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (start) state_nx = SETTLE;
         SETTLE: if (cnt == CNT_LAST) state_nx = CHECK;
         CHECK:  state_nx = (vec == 2'd3) ? DONE : SETTLE;
         DONE:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec         <= 2'd0;
         cnt         <= 4'd0;
         a_out       <= 1'b0;
         b_out       <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= 3'd0;
         fail_vector <= 4'd0;
`ifdef GATE_CHK_MISMATCH_EN
         mismatch_bits <= 7'd0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  vec         <= 2'd0;
                  cnt         <= 4'd0;
                  a_out       <= 1'b0;
                  b_out       <= 1'b0;
                  pass        <= 1'b0;
                  err_count   <= 3'd0;
                  fail_vector <= 4'd0;
`ifdef GATE_CHK_MISMATCH_EN
                  mismatch_bits <= 7'd0;
`endif
               end
            end
            SETTLE: cnt <= cnt + 4'd1;
            CHECK: begin
               if (miss && !fail_vector[vec]) begin
                  fail_vector[vec] <= 1'b1;
                  err_count        <= err_count + 3'd1;
               end
`ifdef GATE_CHK_MISMATCH_EN
               mismatch_bits <= mismatch_bits | (gates_in ^ expected);
`endif
               if (vec != 2'd3) begin
                  vec   <= vec_nx;
                  a_out <= vec_nx[1];
                  b_out <= vec_nx[0];
                  cnt   <= 4'd0;
               end
            end
            DONE: begin
               done <= 1'b1;
               pass <= (err_count == 3'd0);
            end
         endcase
      end
   end

endmodule
